// File: rtl/accumulator_drain.sv
// Drains the back-buffer banks entry by entry onto a valid/ready stream, one packed word per entry.
// Optional per-lane ReLU post-processing is enabled by defining ACCUMULATOR_DRAIN_RELU_EN.
module accumulator_drain #(
  parameter int unsigned BUFFER_WIDTH           = 8,
  parameter int unsigned SMALLEST_ELEMENT_WIDTH = 4,
  localparam int unsigned W  = 4 * SMALLEST_ELEMENT_WIDTH,
  localparam int unsigned AW = $clog2(BUFFER_WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    bitwidth,
  output logic [AW-1:0] back_buffer_bank_entry,
  input  logic [W-1:0]  back_buffer_data_read,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int unsigned Sew = SMALLEST_ELEMENT_WIDTH;

  typedef enum logic [1:0] {StIdle, StDrain, StFlush} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [W-1:0]  data_d;
  logic          valid_d, last_d, done_d;
  logic          load, cnt_max;
  logic [W-1:0]  proc;

  // A new word may enter the output register when it is empty or being taken this cycle.
  assign load    = !out_valid || out_ready;
  assign cnt_max = (cnt_q == AW'(BUFFER_WIDTH - 1));

`ifdef ACCUMULATOR_DRAIN_RELU_EN
  always_comb begin
    proc = back_buffer_data_read;
    case (mode_q)
      2'd0: begin
        for (int i = 0; i < 4; i++) begin
          if (back_buffer_data_read[(i+1)*Sew-1]) proc[i*Sew +: Sew] = '0;
        end
      end
      2'd1: begin
        for (int i = 0; i < 2; i++) begin
          if (back_buffer_data_read[(i+1)*2*Sew-1]) proc[i*2*Sew +: 2*Sew] = '0;
        end
      end
      default: begin
        if (back_buffer_data_read[W-1]) proc = '0;
      end
    endcase
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode_q;
  assign proc        = back_buffer_data_read;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StDrain;
      StDrain: if (load && cnt_max) state_d = StFlush;
      StFlush: if (out_valid && out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    data_d  = out_data;
    valid_d = out_valid;
    last_d  = out_last;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d = bitwidth;
          cnt_d  = '0;
        end
      end
      StDrain: begin
        if (load) begin
          data_d  = proc;
          valid_d = 1'b1;
          last_d  = cnt_max;
          cnt_d   = cnt_q + 1'b1;  // wraps to 0 after the last entry
        end
      end
      StFlush: begin
        if (out_valid && out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign back_buffer_bank_entry = (state_q == StDrain) ? cnt_q : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      mode_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      busy      <= (state_d != StIdle);
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_accumulator_drain.sv
// Scoreboard bench for accumulator_drain: expected words are queued at start and checked on handshake.
module tb_accumulator_drain;

  localparam int BW = 8;
  localparam int S  = 4;
  localparam int W  = 4 * S;
`ifdef ACCUMULATOR_DRAIN_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, out_ready;
  logic [1:0]   bitwidth;
  logic [2:0]   entry;
  logic [W-1:0] rd_data, out_data;
  logic         out_valid, out_last, busy, done;
  logic [W-1:0] bank [BW];

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];

  always #5 clk = ~clk;

  assign rd_data = bank[entry];

  accumulator_drain #(
    .BUFFER_WIDTH          (BW),
    .SMALLEST_ELEMENT_WIDTH(S)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .bitwidth              (bitwidth),
    .back_buffer_bank_entry(entry),
    .back_buffer_data_read (rd_data),
    .out_data              (out_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_last              (out_last),
    .busy                  (busy),
    .done                  (done)
  );

  // Reference post-processing: zero any lane whose sign bit is set (ReLU build only).
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [1:0] m);
    logic [W-1:0] r;
    int lw;
    r  = d;
    lw = (m == 2'd0) ? S : (m == 2'd1) ? 2 * S : W;
    for (int b = 0; b < W; b += lw) begin
      if (Relu && d[b+lw-1]) begin
        for (int k = 0; k < lw; k++) r[b+k] = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    #3;
    vectors++;
    if ({out_data, out_valid, out_last, busy, done, entry} !== '0) begin
      errors++;
      $display("FAIL reset_async: got data %h v%b l%b busy%b done%b entry %0d, required all 0",
               out_data, out_valid, out_last, busy, done, entry);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, busy, done, entry} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got v%b busy%b done%b entry %0d, required 0 0 0 0",
               out_valid, busy, done, entry);
    end
  endtask

  task automatic test_drain_stream(input logic [1:0] bw, input logic [W-1:0] base,
                                   input bit toggle, input bit poke, input string name);
    int hs, last_hs, first_v, dones;
    logic [W-1:0] prev_data, exp_d;
    logic prev_last, stalled, exp_l;
    hs = 0; last_hs = -1; first_v = -1; dones = 0; stalled = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    for (int e = 0; e < BW; e++) bank[e] = base + W'(e);
    for (int e = 0; e < BW; e++) begin
      exp_q.push_back(model(bank[e], bw));
      exp_last_q.push_back(e == BW - 1);
    end
    out_ready = 1'b1;
    bitwidth  = bw;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 60 && dones == 0; c++) begin
      @(negedge clk);
      if (out_valid && first_v < 0) first_v = c;
      if (stalled) begin
        vectors++;
        if (!out_valid || out_data !== prev_data || out_last !== prev_last) begin
          errors++;
          $display("FAIL %s stall_hold: got v%b %h l%b, required v1 %h l%b",
                   name, out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (done) begin
        dones++;
        vectors++;
        if (last_hs !== c - 1 || hs !== BW || busy !== 1'b0 || first_v !== 1) begin
          errors++;
          $display("FAIL %s done: got last_hs %0d words %0d busy %b first_valid %0d, required %0d %0d 0 1",
                   name, last_hs, hs, busy, first_v, c - 1, BW);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_word: got %h, required no word", name, out_data);
        end else begin
          exp_d = exp_q.pop_front();
          exp_l = exp_last_q.pop_front();
          if (out_data !== exp_d || out_last !== exp_l) begin
            errors++;
            $display("FAIL %s word%0d: got %h last %b, required %h last %b",
                     name, hs, out_data, out_last, exp_d, exp_l);
          end
        end
        if (!toggle && hs > 0) begin
          vectors++;
          if (last_hs != c - 1) begin
            errors++;
            $display("FAIL %s gap: got handshake at cycle %0d, required %0d", name, c, last_hs + 1);
          end
        end
        hs++;
        last_hs = c;
      end
      stalled   = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      if (poke) begin
        start    = (c == 2);
        bitwidth = ~bw;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (dones == 0) begin
      errors++;
      $display("FAIL %s timeout: got %0d words and no done, required %0d words and done", name, hs, BW);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (done || out_valid || busy) begin
        errors++;
        $display("FAIL %s quiet: got done %b valid %b busy %b, required 0 0 0",
                 name, done, out_valid, busy);
      end
    end
  endtask

  task automatic test_reset_mid;
    int hs;
    bit seen_done;
    hs = 0; seen_done = 1'b0;
    for (int e = 0; e < BW; e++) bank[e] = 16'h2000 + W'(e);
    out_ready = 1'b1;
    bitwidth  = 2'd2;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && hs < 3; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) hs++;
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (hs != 3 || {out_data, out_valid, out_last, busy, done, entry} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got words %0d data %h v%b l%b busy%b done%b entry %0d, required 3 and all 0",
               hs, out_data, out_valid, out_last, busy, done, entry);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || out_valid) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done) begin
      errors++;
      $display("FAIL reset_mid_quiet: got done or valid after reset, required neither");
    end
  endtask

  task automatic test_lanes;
    logic [W-1:0] vec [4];
    logic [1:0]   md  [4];
    vec[0] = 16'hF87F; md[0] = 2'd0;
    vec[1] = 16'h80FF; md[1] = 2'd1;
    vec[2] = 16'h80FF; md[2] = 2'd2;
    vec[3] = 16'h7FFF; md[3] = 2'd2;
    for (int i = 0; i < 4; i++) test_drain_stream(md[i], vec[i], 1'b0, 1'b0, "lanes");
  endtask

  initial begin
    start     = 1'b0;
    bitwidth  = 2'd0;
    out_ready = 1'b0;
    for (int e = 0; e < BW; e++) bank[e] = '0;
    test_reset;
    test_drain_stream(2'd2, 16'h1000, 1'b0, 1'b0, "passthrough");
    test_drain_stream(2'd2, 16'h1000, 1'b1, 1'b0, "backpressure");
    test_drain_stream(2'd2, 16'h1080, 1'b0, 1'b1, "restart");
    test_reset_mid;
    test_drain_stream(2'd2, 16'h1000, 1'b0, 1'b0, "after_reset");
    test_lanes;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
